axi_slave: RTL and testbench



---
 rtl/axi_slave_if.sv | 58 +++++
 rtl/axi_slave.sv | 262 ++++++++++++++++++++++++++
 tb/tb_axi_slave.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_if.sv
//============================================================================
// Module  : axi_pkg / axi_write_interface / axi_read_interface
// Brief   : AXI4-Lite response type and write/read channel bundles.
// Revision: 1.0
//============================================================================
`default_nettype none

package axi_pkg;
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_response_t;
endpackage

interface axi_write_interface;
    import axi_pkg::*;
    logic [31:0]   AWADDR;
    logic          AWVALID;
    logic          AWREADY;
    logic [31:0]   WDATA;
    logic [3:0]    WSTRB;
    logic          WVALID;
    logic          WREADY;
    axi_response_t BRESP;
    logic          BVALID;
    logic          BREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  AWREADY, WREADY, BRESP, BVALID
    );
    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output AWREADY, WREADY, BRESP, BVALID
    );
endinterface

interface axi_read_interface;
    import axi_pkg::*;
    logic [31:0]   ARADDR;
    logic          ARVALID;
    logic          ARREADY;
    logic [31:0]   RDATA;
    axi_response_t RRESP;
    logic          RVALID;
    logic          RREADY;

    modport master (
        output ARADDR, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RVALID
    );
    modport slave (
        input  ARADDR, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RVALID
    );
endinterface

`default_nettype wire

// File: rtl/axi_slave.sv
//============================================================================
// Module  : axi_slave
// Brief   : Single-beat AXI4-Lite responder forwarding accesses to a simple
//           request/done device port, with address decode and timeout.
// Revision: 1.0
//============================================================================
`default_nettype none

module axi_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] ADDR_LOW  = 32'h0000_0000,
    parameter logic [31:0] ADDR_HIGH = 32'h0000_0FFF,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic               axi_ACLK,
    input  logic               axi_ARESET,
    axi_write_interface.slave  write_channel,
    axi_read_interface.slave   read_channel,
    output logic               write_request_o,
    output logic [31:0]        write_address_o,
    output logic [31:0]        write_data_o,
    output logic [3:0]         write_strobe_o,
    input  logic               write_done_i,
    input  logic               write_error_i,
    output logic               read_request_o,
    output logic [31:0]        read_address_o,
    input  logic [31:0]        read_data_i,
    input  logic               read_done_i,
    input  logic               read_error_i
);

    localparam int unsigned c_timer_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {W_IDLE, W_DEVICE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DEVICE, R_RESP} r_state_t;

    // Unsigned wrap makes this a single compare for any LOW <= HIGH window.
    function automatic logic f_in_range(input logic [31:0] addr);
        return (addr - ADDR_LOW) <= (ADDR_HIGH - ADDR_LOW);
    endfunction

    w_state_t               w_state_q, w_state_d;
    logic                   awready_q, awready_d;
    logic                   wready_q, wready_d;
    logic                   aw_held_q, aw_held_d;
    logic                   w_held_q, w_held_d;
    logic [31:0]            waddr_q, waddr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic                   wreq_q, wreq_d;
    logic                   bvalid_q, bvalid_d;
    axi_response_t          bresp_q, bresp_d;
    logic [c_timer_w-1:0]   wtimer_q, wtimer_d;

    r_state_t               r_state_q, r_state_d;
    logic                   arready_q, arready_d;
    logic [31:0]            raddr_q, raddr_d;
    logic                   rreq_q, rreq_d;
    logic                   rvalid_q, rvalid_d;
    logic [31:0]            rdata_q, rdata_d;
    axi_response_t          rresp_q, rresp_d;
    logic [c_timer_w-1:0]   rtimer_q, rtimer_d;

    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_ar_hs;

    assign w_aw_hs = write_channel.AWVALID & awready_q;
    assign w_w_hs  = write_channel.WVALID & wready_q;
    assign w_ar_hs = read_channel.ARVALID & arready_q;

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wreq_d    = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wtimer_d  = wtimer_q;
        case (w_state_q)
            W_IDLE: begin
                if (w_aw_hs) begin
                    aw_held_d = 1'b1;
                    waddr_d   = write_channel.AWADDR;
                end
                if (w_w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = write_channel.WDATA;
                    wstrb_d  = write_channel.WSTRB;
                end
                awready_d = ~aw_held_d;
                wready_d  = ~w_held_d;
                if (aw_held_d && w_held_d) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    if (f_in_range(waddr_d)) begin
                        w_state_d = W_DEVICE;
                        wreq_d    = 1'b1;
                        wtimer_d  = '0;
                    end else begin
                        w_state_d = W_RESP;
                        bvalid_d  = 1'b1;
                        bresp_d   = SLVERR;
                    end
                end
            end
            W_DEVICE: begin
                if (write_done_i) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = write_error_i ? SLVERR : OKAY;
                end else if (wtimer_q == c_timer_last) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = SLVERR;
                end else begin
                    wtimer_d = wtimer_q + 1'b1;
                end
            end
            W_RESP: begin
                if (write_channel.BREADY) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge axi_ACLK or posedge axi_ARESET) begin
        if (axi_ARESET) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wreq_q    <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            wtimer_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wreq_q    <= wreq_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            wtimer_q  <= wtimer_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        raddr_d   = raddr_q;
        rreq_d    = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rtimer_d  = rtimer_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (w_ar_hs) begin
                    arready_d = 1'b0;
                    raddr_d   = read_channel.ARADDR;
                    if (f_in_range(read_channel.ARADDR)) begin
                        r_state_d = R_DEVICE;
                        rreq_d    = 1'b1;
                        rtimer_d  = '0;
                    end else begin
                        r_state_d = R_RESP;
                        rvalid_d  = 1'b1;
                        rdata_d   = '0;
                        rresp_d   = SLVERR;
                    end
                end
            end
            R_DEVICE: begin
                if (read_done_i) begin
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                    rdata_d   = read_data_i;
                    rresp_d   = read_error_i ? SLVERR : OKAY;
                end else if (rtimer_q == c_timer_last) begin
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                    rdata_d   = '0;
                    rresp_d   = SLVERR;
                end else begin
                    rtimer_d = rtimer_q + 1'b1;
                end
            end
            R_RESP: begin
                if (read_channel.RREADY) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_ACLK or posedge axi_ARESET) begin
        if (axi_ARESET) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            raddr_q   <= '0;
            rreq_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            rtimer_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            raddr_q   <= raddr_d;
            rreq_q    <= rreq_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rtimer_q  <= rtimer_d;
        end
    end

    assign write_channel.AWREADY = awready_q;
    assign write_channel.WREADY  = wready_q;
    assign write_channel.BVALID  = bvalid_q;
    assign write_channel.BRESP   = bresp_q;
    assign read_channel.ARREADY  = arready_q;
    assign read_channel.RVALID   = rvalid_q;
    assign read_channel.RDATA    = rdata_q;
    assign read_channel.RRESP    = rresp_q;

    assign write_request_o = wreq_q;
    assign write_address_o = waddr_q;
    assign write_data_o    = wdata_q;
    assign write_strobe_o  = wstrb_q;
    assign read_request_o  = rreq_q;
    assign read_address_o  = raddr_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_slave.sv
//============================================================================
// Module  : tb_axi_slave
// Brief   : Directed self-checking bench for axi_slave.
// Revision: 1.0
//============================================================================
`default_nettype none

module tb_axi_slave;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_request_o;
    logic [31:0] write_address_o;
    logic [31:0] write_data_o;
    logic [3:0]  write_strobe_o;
    logic        write_done_i;
    logic        write_error_i;
    logic        read_request_o;
    logic [31:0] read_address_o;
    logic [31:0] read_data_i;
    logic        read_done_i;
    logic        read_error_i;

    int checks = 0;
    int errors = 0;

    axi_write_interface wif ();
    axi_read_interface  rif ();

    axi_slave #(
        .ADDR_LOW  (32'h0000_0000),
        .ADDR_HIGH (32'h0000_0FFF),
        .TIMEOUT   (16)
    ) dut (
        .axi_ACLK        (clk),
        .axi_ARESET      (rst),
        .write_channel   (wif),
        .read_channel    (rif),
        .write_request_o (write_request_o),
        .write_address_o (write_address_o),
        .write_data_o    (write_data_o),
        .write_strobe_o  (write_strobe_o),
        .write_done_i    (write_done_i),
        .write_error_i   (write_error_i),
        .read_request_o  (read_request_o),
        .read_address_o  (read_address_o),
        .read_data_i     (read_data_i),
        .read_done_i     (read_done_i),
        .read_error_i    (read_error_i)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wif.AWADDR = '0; wif.AWVALID = 1'b0; wif.WDATA = '0; wif.WSTRB = '0;
        wif.WVALID = 1'b0; wif.BREADY = 1'b0;
        rif.ARADDR = '0; rif.ARVALID = 1'b0; rif.RREADY = 1'b0;
        write_done_i = 1'b0; write_error_i = 1'b0;
        read_data_i = '0; read_done_i = 1'b0; read_error_i = 1'b0;
        step();
        step();
        checks++;
        if ({wif.AWREADY, wif.WREADY, rif.ARREADY, wif.BVALID, rif.RVALID,
             write_request_o, read_request_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {wif.AWREADY, wif.WREADY, rif.ARREADY, wif.BVALID, rif.RVALID,
                      write_request_o, read_request_o});
        end
        checks++;
        if ({write_address_o, write_data_o, write_strobe_o, read_address_o, rif.RDATA,
             wif.BRESP, rif.RRESP} !== '0) begin
            errors++;
            $display("FAIL reset_fields: got %h/%h/%h/%h/%h/%b/%b required all zero",
                     write_address_o, write_data_o, write_strobe_o, read_address_o,
                     rif.RDATA, wif.BRESP, rif.RRESP);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({wif.AWREADY, wif.WREADY, rif.ARREADY} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready: got %b required 111",
                     {wif.AWREADY, wif.WREADY, rif.ARREADY});
        end
    endtask

    task automatic test_write_basic();
        wif.AWADDR = 32'h0000_0010; wif.AWVALID = 1'b1;
        wif.WDATA = 32'hDEAD_BEEF; wif.WSTRB = 4'hF; wif.WVALID = 1'b1;
        step();
        wif.AWVALID = 1'b0; wif.WVALID = 1'b0;
        checks++;
        if ({write_request_o, write_address_o, write_data_o, write_strobe_o,
             wif.AWREADY, wif.WREADY, wif.BVALID} !== {1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000}) begin
            errors++;
            $display("FAIL wr_basic_req: got req=%b a=%h d=%h s=%h rdy=%b%b bv=%b required 1/10/deadbeef/f/00/0",
                     write_request_o, write_address_o, write_data_o, write_strobe_o,
                     wif.AWREADY, wif.WREADY, wif.BVALID);
        end
        write_done_i = 1'b1;
        step();
        write_done_i = 1'b0;
        checks++;
        if ({write_request_o, wif.BVALID, wif.BRESP} !== {1'b0, 1'b1, OKAY}) begin
            errors++;
            $display("FAIL wr_basic_resp: got req=%b bv=%b br=%b required 0/1/00",
                     write_request_o, wif.BVALID, wif.BRESP);
        end
        wif.BREADY = 1'b1;
        step();
        wif.BREADY = 1'b0;
        checks++;
        if ({wif.BVALID, wif.AWREADY, wif.WREADY} !== 3'b011) begin
            errors++;
            $display("FAIL wr_basic_done: got bv/awr/wr=%b required 011",
                     {wif.BVALID, wif.AWREADY, wif.WREADY});
        end
    endtask

    task automatic test_write_w_first_stall();
        wif.WDATA = 32'hCAFE_F00D; wif.WSTRB = 4'h3; wif.WVALID = 1'b1;
        step();
        wif.WVALID = 1'b0;
        checks++;
        if ({wif.WREADY, wif.AWREADY, write_request_o} !== 3'b010) begin
            errors++;
            $display("FAIL wfirst_ready: got wr/awr/req=%b required 010",
                     {wif.WREADY, wif.AWREADY, write_request_o});
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (write_request_o !== 1'b0) begin
                errors++;
                $display("FAIL wfirst_noreq: got %b required 0", write_request_o);
            end
        end
        wif.AWADDR = 32'h0000_0020; wif.AWVALID = 1'b1;
        step();
        wif.AWVALID = 1'b0;
        checks++;
        if ({write_request_o, write_address_o, write_data_o, write_strobe_o}
                !== {1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h3}) begin
            errors++;
            $display("FAIL wfirst_req: got req=%b a=%h d=%h s=%h required 1/20/cafef00d/3",
                     write_request_o, write_address_o, write_data_o, write_strobe_o);
        end
        step();
        checks++;
        if (write_request_o !== 1'b0) begin
            errors++;
            $display("FAIL wfirst_single: got %b required 0", write_request_o);
        end
        write_done_i = 1'b1; write_error_i = 1'b1;
        step();
        write_done_i = 1'b0; write_error_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({wif.BVALID, wif.BRESP, write_request_o, wif.AWREADY, wif.WREADY}
                    !== {1'b1, SLVERR, 3'b000}) begin
                errors++;
                $display("FAIL wfirst_stall: got bv=%b br=%b req=%b rdy=%b%b required 1/10/0/00",
                         wif.BVALID, wif.BRESP, write_request_o, wif.AWREADY, wif.WREADY);
            end
            step();
        end
        wif.BREADY = 1'b1;
        step();
        wif.BREADY = 1'b0;
        checks++;
        if ({wif.BVALID, wif.AWREADY, wif.WREADY} !== 3'b011) begin
            errors++;
            $display("FAIL wfirst_done: got %b required 011",
                     {wif.BVALID, wif.AWREADY, wif.WREADY});
        end
    endtask

    task automatic test_read_error();
        rif.ARADDR = 32'h0000_0FFC; rif.ARVALID = 1'b1;
        step();
        rif.ARVALID = 1'b0;
        checks++;
        if ({read_request_o, read_address_o, rif.ARREADY} !== {1'b1, 32'h0000_0FFC, 1'b0}) begin
            errors++;
            $display("FAIL rd_req: got req=%b a=%h arr=%b required 1/ffc/0",
                     read_request_o, read_address_o, rif.ARREADY);
        end
        step();
        checks++;
        if ({read_request_o, rif.RVALID} !== 2'b00) begin
            errors++;
            $display("FAIL rd_wait: got req/rv=%b required 00", {read_request_o, rif.RVALID});
        end
        step();
        read_done_i = 1'b1; read_data_i = 32'h1234_5678; read_error_i = 1'b1;
        step();
        read_done_i = 1'b0; read_data_i = 32'hFFFF_FFFF; read_error_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({rif.RVALID, rif.RDATA, rif.RRESP, rif.ARREADY} !== {1'b1, 32'h1234_5678, SLVERR, 1'b0}) begin
                errors++;
                $display("FAIL rd_resp: got rv=%b d=%h rr=%b arr=%b required 1/12345678/10/0",
                         rif.RVALID, rif.RDATA, rif.RRESP, rif.ARREADY);
            end
            if (i == 2) rif.RREADY = 1'b1;
            step();
        end
        rif.RREADY = 1'b0;
        checks++;
        if ({rif.RVALID, rif.ARREADY} !== 2'b01) begin
            errors++;
            $display("FAIL rd_done: got rv/arr=%b required 01", {rif.RVALID, rif.ARREADY});
        end
    endtask

    task automatic test_out_of_range();
        wif.AWADDR = 32'h0000_1000; wif.AWVALID = 1'b1;
        wif.WDATA = 32'h0101_0101; wif.WSTRB = 4'hF; wif.WVALID = 1'b1;
        rif.ARADDR = 32'hFFFF_FFFC; rif.ARVALID = 1'b1;
        step();
        wif.AWVALID = 1'b0; wif.WVALID = 1'b0; rif.ARVALID = 1'b0;
        checks++;
        if ({write_request_o, read_request_o} !== 2'b00) begin
            errors++;
            $display("FAIL oor_noreq: got wreq/rreq=%b required 00", {write_request_o, read_request_o});
        end
        checks++;
        if ({wif.BVALID, wif.BRESP} !== {1'b1, SLVERR}) begin
            errors++;
            $display("FAIL oor_bresp: got bv=%b br=%b required 1/10", wif.BVALID, wif.BRESP);
        end
        checks++;
        if ({rif.RVALID, rif.RRESP, rif.RDATA} !== {1'b1, SLVERR, 32'h0}) begin
            errors++;
            $display("FAIL oor_rresp: got rv=%b rr=%b d=%h required 1/10/0",
                     rif.RVALID, rif.RRESP, rif.RDATA);
        end
        wif.BREADY = 1'b1; rif.RREADY = 1'b1;
        step();
        wif.BREADY = 1'b0; rif.RREADY = 1'b0;
        checks++;
        if ({wif.BVALID, rif.RVALID, wif.AWREADY, wif.WREADY, rif.ARREADY} !== 5'b00111) begin
            errors++;
            $display("FAIL oor_done: got %b required 00111",
                     {wif.BVALID, rif.RVALID, wif.AWREADY, wif.WREADY, rif.ARREADY});
        end
    endtask

    task automatic test_timeout();
        wif.AWADDR = 32'h0000_0040; wif.AWVALID = 1'b1;
        wif.WDATA = 32'h0000_00AA; wif.WSTRB = 4'h1; wif.WVALID = 1'b1;
        step();
        wif.AWVALID = 1'b0; wif.WVALID = 1'b0;
        checks++;
        if (write_request_o !== 1'b1) begin
            errors++;
            $display("FAIL to_req: got %b required 1", write_request_o);
        end
        for (int k = 1; k <= 15; k++) begin
            step();
            checks++;
            if ({wif.BVALID, write_address_o, write_request_o} !== {1'b0, 32'h0000_0040, 1'b0}) begin
                errors++;
                $display("FAIL to_wait: cycle %0d got bv=%b a=%h req=%b required 0/40/0",
                         k, wif.BVALID, write_address_o, write_request_o);
            end
        end
        step();
        checks++;
        if ({wif.BVALID, wif.BRESP} !== {1'b1, SLVERR}) begin
            errors++;
            $display("FAIL to_resp: got bv=%b br=%b required 1/10", wif.BVALID, wif.BRESP);
        end
        write_done_i = 1'b1; wif.BREADY = 1'b1;
        step();
        wif.BREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({wif.BVALID, write_request_o, wif.AWREADY, wif.WREADY} !== 4'b0011) begin
                errors++;
                $display("FAIL to_stray: got bv/req/awr/wr=%b required 0011",
                         {wif.BVALID, write_request_o, wif.AWREADY, wif.WREADY});
            end
            step();
        end
        write_done_i = 1'b0;
        wif.AWADDR = 32'h0000_0044; wif.AWVALID = 1'b1;
        wif.WDATA = 32'h1122_3344; wif.WSTRB = 4'h8; wif.WVALID = 1'b1;
        step();
        wif.AWVALID = 1'b0; wif.WVALID = 1'b0;
        write_done_i = 1'b1;
        step();
        write_done_i = 1'b0;
        checks++;
        if ({wif.BVALID, wif.BRESP} !== {1'b1, OKAY}) begin
            errors++;
            $display("FAIL to_next: got bv=%b br=%b required 1/00", wif.BVALID, wif.BRESP);
        end
        wif.BREADY = 1'b1;
        step();
        wif.BREADY = 1'b0;
    endtask

    task automatic test_async_reset();
        wif.AWADDR = 32'h0000_0080; wif.AWVALID = 1'b1;
        wif.WDATA = 32'h7777_7777; wif.WSTRB = 4'hF; wif.WVALID = 1'b1;
        rif.ARADDR = 32'h0000_0100; rif.ARVALID = 1'b1;
        step();
        wif.AWVALID = 1'b0; wif.WVALID = 1'b0; rif.ARVALID = 1'b0;
        read_done_i = 1'b1; read_data_i = 32'hA5A5_A5A5;
        step();
        read_done_i = 1'b0;
        checks++;
        if ({rif.RVALID, wif.BVALID, write_address_o} !== {2'b10, 32'h0000_0080}) begin
            errors++;
            $display("FAIL ar_pre: got rv=%b bv=%b a=%h required 1/0/80",
                     rif.RVALID, wif.BVALID, write_address_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rif.RVALID, wif.BVALID, write_request_o, read_request_o,
             wif.AWREADY, wif.WREADY, rif.ARREADY} !== 7'b0) begin
            errors++;
            $display("FAIL ar_async: got %b required 0000000",
                     {rif.RVALID, wif.BVALID, write_request_o, read_request_o,
                      wif.AWREADY, wif.WREADY, rif.ARREADY});
        end
        checks++;
        if ({write_address_o, read_address_o, rif.RDATA} !== 96'h0) begin
            errors++;
            $display("FAIL ar_fields: got %h/%h/%h required 0/0/0",
                     write_address_o, read_address_o, rif.RDATA);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({wif.AWREADY, wif.WREADY, rif.ARREADY, wif.BVALID, rif.RVALID} !== 5'b11100) begin
            errors++;
            $display("FAIL ar_release: got %b required 11100",
                     {wif.AWREADY, wif.WREADY, rif.ARREADY, wif.BVALID, rif.RVALID});
        end
        wif.AWADDR = 32'h0000_0084; wif.AWVALID = 1'b1;
        wif.WDATA = 32'h5555_AAAA; wif.WSTRB = 4'hF; wif.WVALID = 1'b1;
        rif.ARADDR = 32'h0000_0088; rif.ARVALID = 1'b1;
        step();
        wif.AWVALID = 1'b0; wif.WVALID = 1'b0; rif.ARVALID = 1'b0;
        checks++;
        if ({write_request_o, read_request_o, write_address_o, read_address_o}
                !== {2'b11, 32'h0000_0084, 32'h0000_0088}) begin
            errors++;
            $display("FAIL ar_pair_req: got req=%b%b wa=%h ra=%h required 11/84/88",
                     write_request_o, read_request_o, write_address_o, read_address_o);
        end
        write_done_i = 1'b1; read_done_i = 1'b1; read_data_i = 32'h0BAD_F00D;
        step();
        write_done_i = 1'b0; read_done_i = 1'b0;
        checks++;
        if ({wif.BVALID, wif.BRESP, rif.RVALID, rif.RRESP, rif.RDATA}
                !== {1'b1, OKAY, 1'b1, OKAY, 32'h0BAD_F00D}) begin
            errors++;
            $display("FAIL ar_pair_resp: got bv=%b br=%b rv=%b rr=%b d=%h required 1/00/1/00/0badf00d",
                     wif.BVALID, wif.BRESP, rif.RVALID, rif.RRESP, rif.RDATA);
        end
        wif.BREADY = 1'b1; rif.RREADY = 1'b1;
        step();
        wif.BREADY = 1'b0; rif.RREADY = 1'b0;
        checks++;
        if ({wif.BVALID, rif.RVALID, wif.AWREADY, wif.WREADY, rif.ARREADY} !== 5'b00111) begin
            errors++;
            $display("FAIL ar_pair_done: got %b required 00111",
                     {wif.BVALID, rif.RVALID, wif.AWREADY, wif.WREADY, rif.ARREADY});
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_w_first_stall();
        test_read_error();
        test_out_of_range();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
